conv_layer_ctrl: RTL
====================

# conv_layer_ctrl

Sequencer for the convolution filter array. It walks 3x3 valid-convolution window positions across one input feature map, in raster order, and issues one window per accepted slot to the filter array. A CONV_LAT-deep tag pipeline carries each window's coordinates so they leave aligned with that window's filter result. Issue is throttled by the window buffer's ready signal and by a credit count of free downstream result slots, because the filter array itself cannot stall.

## Interface
- IMG_W, 16, feature-map width in pixels (≥3)
- IMG_H, 16, feature-map height in pixels (≥3)
- COORD_W, 8, coordinate width; 2^COORD_W ≥ max(IMG_W, IMG_H)
- CONV_LAT, 3, cycles from window issue to filter-array output register (≥1)
- CREDITS, 4, downstream result slots (≥1)

Ports (the reset is asynchronous, active-high):
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- start_i  in  1  start one frame; sampled only in IDLE
- fetch_ready_i  in  1  window buffer holds the window at (win_x_o, win_y_o)
- credit_ret_i  in  1  one downstream slot freed (1-cycle pulse)
- win_valid_o  out  1  window issued this cycle
- win_x_o, win_y_o  out  COORD_W  top-left of the current window
- res_valid_o  out  1  filter-array output valid this cycle
- res_x_o, res_y_o  out  COORD_W  coordinate of the valid result
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  1-cycle pulse at frame completion
- perf_stall_o  out  32  present only with CONV_CTRL_PERF_EN

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start_i. In the same transition, x and y counters are cleared.
  - RUN→DRAIN on the cycle the last window (IMG_W-3, IMG_H-3) issues.
  - DRAIN→DONE when the tag pipeline is empty.
  - DONE→IDLE unconditionally.
- Issue condition: win_valid_o = (state==RUN) & fetch_ready_i & (credits≠0). It is a combinational AND of registered state and the inputs.
- On issue:
  - x increments.
  - At x==IMG_W-3, x wraps to 0 and y increments.
  - Each frame issues exactly (IMG_W-2)*(IMG_H-2) windows.
- Credits: a counter of width clog2(CREDITS+1), reset to CREDITS.
  - Issue only: credits -1.
  - credit_ret_i only: credits +1.
  - Both in the same cycle: unchanged.
  - credit_ret_i at credits==CREDITS is ignored (saturates).
- Tag pipeline: CONV_LAT stages of {valid, x, y}, shifted every cycle. The stage-0 input is {win_valid_o, win_x_o, win_y_o}. res_* are driven from the last stage.
- start_i outside IDLE is ignored.
- Credits persist across frames and are not reset by start_i.
- Coordinates hold their last value while no issue occurs.

## Timing
- Reset values: all of the following are 0.
  - Outputs: win_valid_o, win_x_o, win_y_o, res_valid_o, res_x_o, res_y_o, busy_o, done_o, perf_stall_o.
  - State: FSM in IDLE, tag pipeline cleared, credits set to CREDITS.
- Reset asserted mid-frame: the frame is abandoned. No further res_valid_o and no done_o follow.
- Start timing: start_i high at edge k gives busy_o=1 from cycle k+1. The first issue is possible in cycle k+1.
- Issue-to-result latency: an issue in cycle n gives res_valid_o=1 in cycle n+CONV_LAT with that window's coordinates.
- Done timing: done_o is high the cycle after the last res_valid_o. busy_o falls one cycle later.
- Minimum frame time: with no stalls, (IMG_W-2)*(IMG_H-2)+CONV_LAT+2 cycles from start to IDLE.

## Configuration
- CONV_CTRL_PERF_EN defined:
  - perf_stall_o exists.
  - It counts cycles in RUN where fetch_ready_i=1 and credits=0.
  - It clears on start_i accepted and saturates at 2^32-1.
- CONV_CTRL_PERF_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
All scenarios use IMG_W=5, IMG_H=4, CONV_LAT=3, CREDITS=4.
- Reset then idle: every output is 0 and busy_o=0. start_i during reset has no effect.
- Full frame, fetch_ready_i=1, credit_ret_i pulsed the cycle after each res_valid_o:
  - 6 issues in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - res_valid_o follows each issue by exactly 3 cycles.
  - done_o follows the last result by 1 cycle.
- No credit returns: exactly 4 issues, then win_valid_o=0 while in RUN.
  - One credit_ret_i releases exactly one more issue.
  - With the macro defined, perf_stall_o increments on each blocked cycle.
- Same-cycle issue and credit_ret_i with credits=1: credits stay 1. A credit_ret_i at credits=4 leaves 4.
- fetch_ready_i toggling every other cycle: the issue order is unchanged. Each result coordinate matches the coordinate issued 3 cycles earlier.
- rst_i pulsed after 3 issues: no further res_valid_o appears. A new start_i restarts from (0,0) with credits=4.

Source files
------------

// File: rtl/conv_layer_ctrl_if.sv
// Handshake/result bundle between the convolution sequencer and its neighbours.
// perf_stall_o exists only when CONV_CTRL_PERF_EN is defined.
interface conv_layer_ctrl_if #(
    parameter int unsigned COORD_W = 8
);
    logic               start_i;
    logic               fetch_ready_i;
    logic               credit_ret_i;
    logic               win_valid_o;
    logic [COORD_W-1:0] win_x_o;
    logic [COORD_W-1:0] win_y_o;
    logic               res_valid_o;
    logic [COORD_W-1:0] res_x_o;
    logic [COORD_W-1:0] res_y_o;
    logic               busy_o;
    logic               done_o;
`ifdef CONV_CTRL_PERF_EN
    logic [31:0]        perf_stall_o;
`endif

    modport master (
        input  start_i, fetch_ready_i, credit_ret_i,
        output win_valid_o, win_x_o, win_y_o,
        output res_valid_o, res_x_o, res_y_o,
        output busy_o, done_o
`ifdef CONV_CTRL_PERF_EN
        , output perf_stall_o
`endif
    );

    modport slave (
        output start_i, fetch_ready_i, credit_ret_i,
        input  win_valid_o, win_x_o, win_y_o,
        input  res_valid_o, res_x_o, res_y_o,
        input  busy_o, done_o
`ifdef CONV_CTRL_PERF_EN
        , input perf_stall_o
`endif
    );
endinterface

// File: rtl/conv_layer_ctrl.sv
// Raster-order 3x3 window sequencer with credit-throttled issue and a coordinate tag pipeline.
// Optional stall counter on perf_stall_o when CONV_CTRL_PERF_EN is defined.
module conv_layer_ctrl #(
    parameter int unsigned IMG_W    = 16,
    parameter int unsigned IMG_H    = 16,
    parameter int unsigned COORD_W  = 8,
    parameter int unsigned CONV_LAT = 3,
    parameter int unsigned CREDITS  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    conv_layer_ctrl_if.master  bus
);
    localparam int unsigned        CRED_W   = $clog2(CREDITS + 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(IMG_W - 3);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(IMG_H - 3);
    localparam logic [CRED_W-1:0]  CRED_MAX = CRED_W'(CREDITS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [CRED_W-1:0]  credits_q, credits_d;
    logic [CONV_LAT-1:0] tag_v_q, tag_v_d;
    logic [COORD_W-1:0] tag_x_q [CONV_LAT];
    logic [COORD_W-1:0] tag_x_d [CONV_LAT];
    logic [COORD_W-1:0] tag_y_q [CONV_LAT];
    logic [COORD_W-1:0] tag_y_d [CONV_LAT];
    logic               issue_c;
    logic               pipe_drained_c;

    assign issue_c = (state_q == RUN) && bus.fetch_ready_i && (credits_q != '0);

    // Only the head stage may still hold a result when the next cycle empties the pipe.
    always_comb begin
        pipe_drained_c = 1'b1;
        for (int i = 0; i < int'(CONV_LAT) - 1; i++) begin
            if (tag_v_q[i]) pipe_drained_c = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = RUN;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            RUN: begin
                if (issue_c) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + COORD_W'(1);
                        if (y_q == Y_LAST) state_d = DRAIN;
                    end else begin
                        x_d = x_q + COORD_W'(1);
                    end
                end
            end
            DRAIN:   if (pipe_drained_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A return arriving while all slots are free is dropped.
    always_comb begin
        credits_d = credits_q;
        if (issue_c && !bus.credit_ret_i) begin
            credits_d = credits_q - CRED_W'(1);
        end else if (!issue_c && bus.credit_ret_i && (credits_q != CRED_MAX)) begin
            credits_d = credits_q + CRED_W'(1);
        end
    end

    always_comb begin
        tag_v_d = '0;
        for (int i = 0; i < int'(CONV_LAT); i++) begin
            tag_x_d[i] = '0;
            tag_y_d[i] = '0;
        end
        tag_v_d[0] = issue_c;
        tag_x_d[0] = x_q;
        tag_y_d[0] = y_q;
        for (int i = 1; i < int'(CONV_LAT); i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_x_d[i] = tag_x_q[i-1];
            tag_y_d[i] = tag_y_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            credits_q <= CRED_MAX;
            tag_v_q   <= '0;
            for (int i = 0; i < int'(CONV_LAT); i++) begin
                tag_x_q[i] <= '0;
                tag_y_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            credits_q <= credits_d;
            tag_v_q   <= tag_v_d;
            for (int i = 0; i < int'(CONV_LAT); i++) begin
                tag_x_q[i] <= tag_x_d[i];
                tag_y_q[i] <= tag_y_d[i];
            end
        end
    end

`ifdef CONV_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == IDLE) && bus.start_i) begin
            perf_d = '0;
        end else if ((state_q == RUN) && bus.fetch_ready_i && (credits_q == '0) && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign bus.perf_stall_o = perf_q;
`endif

    assign bus.win_valid_o = issue_c;
    assign bus.win_x_o     = x_q;
    assign bus.win_y_o     = y_q;
    assign bus.res_valid_o = tag_v_q[CONV_LAT-1];
    assign bus.res_x_o     = tag_x_q[CONV_LAT-1];
    assign bus.res_y_o     = tag_y_q[CONV_LAT-1];
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.done_o      = (state_q == DONE);
endmodule
